// File: rtl/param_dequantizer.sv
// Dequantizer between the zig-zag decoder and the IDCT: coef * quant-table entry,
// scaled to fixed point with saturation, over a two-stage valid/ready pipeline.
module param_dequantizer #(
  parameter int COEF_W  = 12,
  parameter int QT_W    = 8,
  parameter int FRAC_W  = 8,
  parameter int OUT_W   = 24,
  parameter int NUM_TBL = 2,
  parameter int BLK_DIM = 8,
  localparam int BLK_BIT = $clog2(BLK_DIM),
  localparam int SEL_W   = (NUM_TBL > 1) ? $clog2(NUM_TBL) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [COEF_W-1:0]        zig_veri_i,
  input  logic [BLK_BIT-1:0]       zig_veri_row_i,
  input  logic [BLK_BIT-1:0]       zig_veri_col_i,
  input  logic [SEL_W-1:0]         zig_tablo_sec_i,
  input  logic                     zig_blok_son_i,
  input  logic                     zig_veri_gecerli_i,
  output logic                     zig_veri_hazir_o,
  output logic [OUT_W-1:0]         idct_veri_o,
  output logic [BLK_BIT-1:0]       idct_veri_row_o,
  output logic [BLK_BIT-1:0]       idct_veri_col_o,
  output logic                     idct_blok_son_o,
  output logic                     idct_veri_gecerli_o,
  input  logic                     idct_veri_hazir_i,
  input  logic                     tablo_yaz_i,
  input  logic [SEL_W-1:0]         tablo_no_i,
  input  logic [2*BLK_BIT-1:0]     tablo_adr_i,
  input  logic [QT_W-1:0]          tablo_veri_i,
  output logic                     doyma_o,
  input  logic                     doyma_temizle_i
);

  localparam int ADR_W = 2 * BLK_BIT;
  localparam int DEPTH = BLK_DIM * BLK_DIM;
  localparam int PW    = COEF_W + QT_W + 1;
  localparam int SW    = PW + FRAC_W;
  localparam int WW    = ((SW > OUT_W) ? SW : OUT_W) + 1;

  localparam logic signed [WW-1:0] MAX_V = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [WW-1:0] MIN_V = {{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // T.81 Annex K.1 / K.2 tables, natural (row-major) order
  localparam int LUMA [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77,
    24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103, 99};
  localparam int CHROMA [64] = '{
    17, 18, 24, 47, 99, 99, 99, 99,
    18, 21, 26, 66, 99, 99, 99, 99,
    24, 26, 56, 99, 99, 99, 99, 99,
    47, 66, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99};

  function automatic logic [QT_W-1:0] default_q(int unsigned t, int unsigned i);
    if (BLK_DIM == 8 && t == 0) return QT_W'(LUMA[i[5:0]]);
    if (BLK_DIM == 8 && t == 1) return QT_W'(CHROMA[i[5:0]]);
    return QT_W'(16);
  endfunction

  logic [QT_W-1:0] tbl [NUM_TBL][DEPTH];

  logic                     s1_valid, s1_last;
  logic signed [COEF_W-1:0] s1_coef;
  logic [BLK_BIT-1:0]       s1_row, s1_col;
  logic [QT_W-1:0]          s1_q;
  logic                     s2_ready, accept, wr_ok;
  logic [SEL_W-1:0]         rd_tbl;
  logic [ADR_W-1:0]         rd_idx;
  logic signed [PW-1:0]     prod;
  logic signed [WW-1:0]     wide;
  logic                     sat_hi, sat_lo;
  logic [OUT_W-1:0]         sat_val;

  assign s2_ready         = !idct_veri_gecerli_o || idct_veri_hazir_i;
  assign zig_veri_hazir_o = !s1_valid || s2_ready;
  assign accept           = zig_veri_gecerli_i && zig_veri_hazir_o;
  assign wr_ok            = tablo_yaz_i && (32'(tablo_no_i) < NUM_TBL);
  assign rd_tbl           = (32'(zig_tablo_sec_i) < NUM_TBL) ? zig_tablo_sec_i : '0;
  assign rd_idx           = ADR_W'(zig_veri_row_i) * ADR_W'(BLK_DIM) + ADR_W'(zig_veri_col_i);

  // The read is registered at the same edge as a write, so a colliding read sees the old entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned t = 0; t < NUM_TBL; t++)
        for (int unsigned i = 0; i < DEPTH; i++)
          tbl[t][i] <= default_q(t, i);
    end else if (wr_ok) begin
      tbl[tablo_no_i][tablo_adr_i] <= tablo_veri_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_coef  <= '0;
      s1_row   <= '0;
      s1_col   <= '0;
      s1_q     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_last  <= zig_blok_son_i;
      s1_coef  <= zig_veri_i;
      s1_row   <= zig_veri_row_i;
      s1_col   <= zig_veri_col_i;
      s1_q     <= tbl[rd_tbl][rd_idx];
    end else if (s2_ready) begin
      s1_valid <= 1'b0;
    end
  end

  always_comb begin
    prod    = PW'(s1_coef) * PW'($signed({1'b0, s1_q}));
    wide    = WW'(prod) <<< FRAC_W;
    sat_hi  = wide > MAX_V;
    sat_lo  = wide < MIN_V;
    sat_val = wide[OUT_W-1:0];
    if (sat_hi) sat_val = MAX_V[OUT_W-1:0];
    if (sat_lo) sat_val = MIN_V[OUT_W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idct_veri_gecerli_o <= 1'b0;
      idct_blok_son_o     <= 1'b0;
      idct_veri_o         <= '0;
      idct_veri_row_o     <= '0;
      idct_veri_col_o     <= '0;
    end else if (s2_ready) begin
      idct_veri_gecerli_o <= s1_valid;
      idct_blok_son_o     <= s1_valid && s1_last;
      if (s1_valid) begin
        idct_veri_o     <= sat_val;
        idct_veri_row_o <= s1_row;
        idct_veri_col_o <= s1_col;
      end
    end
  end

  // A new saturation outranks a simultaneous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                      doyma_o <= 1'b0;
    else if (s2_ready && s1_valid && (sat_hi || sat_lo)) doyma_o <= 1'b1;
    else if (doyma_temizle_i)                       doyma_o <= 1'b0;
  end

endmodule

// File: tb/tb_param_dequantizer.sv
// Scoreboard bench for param_dequantizer: default instance (OUT_W=24) and an
// OUT_W=16 instance share all inputs; a negedge monitor pops expected beats.
module tb_param_dequantizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] coef = '0;
  logic [2:0]  row = '0, col = '0;
  logic        sel = 1'b0, last = 1'b0, vin = 1'b0;
  logic        out_ready = 1'b1;
  logic        twr = 1'b0, tno = 1'b0;
  logic [5:0]  tadr = '0;
  logic [7:0]  tval = '0;
  logic        clr = 1'b0;

  logic        in_ready, in_ready16;
  logic [23:0] out_d;
  logic [15:0] out_d16;
  logic [2:0]  out_row, out_col, out_row16, out_col16;
  logic        out_last, out_last16, out_vld, out_vld16, sat24, sat16;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;

  typedef struct {
    logic signed [23:0] d24;
    logic signed [15:0] d16;
    logic [2:0] row;
    logic [2:0] col;
    logic last;
  } exp_t;
  exp_t sb[$];

  localparam int LUMA [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,  12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,  14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99};

  param_dequantizer dut (
    .clk_i(clk), .rst_i(rst), .zig_veri_i(coef), .zig_veri_row_i(row), .zig_veri_col_i(col),
    .zig_tablo_sec_i(sel), .zig_blok_son_i(last), .zig_veri_gecerli_i(vin),
    .zig_veri_hazir_o(in_ready), .idct_veri_o(out_d), .idct_veri_row_o(out_row),
    .idct_veri_col_o(out_col), .idct_blok_son_o(out_last), .idct_veri_gecerli_o(out_vld),
    .idct_veri_hazir_i(out_ready), .tablo_yaz_i(twr), .tablo_no_i(tno), .tablo_adr_i(tadr),
    .tablo_veri_i(tval), .doyma_o(sat24), .doyma_temizle_i(clr));

  param_dequantizer #(.OUT_W(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .zig_veri_i(coef), .zig_veri_row_i(row), .zig_veri_col_i(col),
    .zig_tablo_sec_i(sel), .zig_blok_son_i(last), .zig_veri_gecerli_i(vin),
    .zig_veri_hazir_o(in_ready16), .idct_veri_o(out_d16), .idct_veri_row_o(out_row16),
    .idct_veri_col_o(out_col16), .idct_blok_son_o(out_last16), .idct_veri_gecerli_o(out_vld16),
    .idct_veri_hazir_i(out_ready), .tablo_yaz_i(twr), .tablo_no_i(tno), .tablo_adr_i(tadr),
    .tablo_veri_i(tval), .doyma_o(sat16), .doyma_temizle_i(clr));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: pops on each transfer, verifies held outputs across stalls.
  logic        held = 1'b0;
  logic [23:0] h_d;
  logic [15:0] h_d16;
  logic [2:0]  h_row, h_col;
  logic        h_last;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_hold", {h_d, h_d16, h_row, h_col, h_last} == {out_d, out_d16, out_row, out_col, out_last}, 1);
        chk("stall_valid", out_vld, 1);
      end
      held = 1'b0;
      if (!out_vld) chk("last_without_valid", out_last || out_last16, 0);
      if (out_vld && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("data24", $signed(out_d), e.d24);
          chk("data16", $signed(out_d16), e.d16);
          chk("valid16", out_vld16, 1);
          chk("row", out_row, e.row);
          chk("col", out_col, e.col);
          chk("last", out_last, e.last);
        end
      end else if (out_vld) begin
        held = 1'b1;
        h_d = out_d; h_d16 = out_d16; h_row = out_row; h_col = out_col; h_last = out_last;
      end
    end
  end

  task automatic send(input int c, input int r, input int cl, input int s, input bit l,
                      input int e24, input int e16);
    exp_t e;
    coef = 12'(c); row = 3'(r); col = 3'(cl); sel = 1'(s); last = l; vin = 1'b1;
    e.d24 = 24'(e24); e.d16 = 16'(e16); e.row = 3'(r); e.col = 3'(cl); e.last = l;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        @(posedge clk);
        #1;
        vin = 1'b0;
        last = 1'b0;
        return;
      end
    end
    chk("send_timeout", 1, 0);
    vin = 1'b0;
    last = 1'b0;
  endtask

  task automatic twrite(input int no, input int adr, input int val);
    twr = 1'b1; tno = 1'(no); tadr = 6'(adr); tval = 8'(val);
    @(posedge clk);
    #1;
    twr = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", out_vld, 0);
    chk("rst_data", out_d, 0);
    chk("rst_last", out_last, 0);
    chk("rst_sat", sat24, 0);
    chk("rst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: luma (0,0)=16, +3 -> 48<<8, valid after two edges
    send(3, 0, 0, 0, 1'b0, 12288, 12288);
    @(negedge clk);
    chk("latency_early", out_vld, 0);
    @(negedge clk);
    chk("latency_2", out_vld, 1);
    drain();

    // 2: chroma (7,7)=99, -2 -> -50688; 16-bit saturates
    send(-2, 7, 7, 1, 1'b1, -50688, -32768);
    drain();
    chk("sat24_after_t2", sat24, 0);
    chk("sat16_after_t2", sat16, 1);
    pulse_clear();
    @(negedge clk);
    chk("sat16_cleared", sat16, 0);
    @(posedge clk);
    #1;

    // 3: 64-coefficient block under a 1010 output-ready pattern
    rdy_mode = 1;
    for (int i = 0; i < 64; i++)
      send(1, i / 8, i % 8, 0, i == 63, LUMA[i] * 256, LUMA[i] * 256);
    rdy_mode = 0;
    drain();

    // 4: write collides with read (old 40), then new 200 visible next cycle
    twr = 1'b1; tno = 1'b0; tadr = 6'd5; tval = 8'd200;
    send(1, 0, 5, 0, 1'b0, 10240, 10240);
    twr = 1'b0;
    send(1, 0, 5, 0, 1'b0, 51200, 32767);
    drain();
    chk("sat24_after_t4", sat24, 0);
    pulse_clear();

    // 5: saturation both directions; clear coincident with a new saturation loses
    twrite(1, 0, 255);
    send(-2048, 0, 0, 1, 1'b0, -8388608, -32768);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    drain();
    chk("sat24_set_wins", sat24, 1);
    chk("sat16_set_wins", sat16, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("sat24_sticky", sat24, 1);
    pulse_clear();
    chk("sat24_clear", sat24, 0);
    chk("sat16_clear", sat16, 0);
    send(2047, 0, 0, 1, 1'b0, 8388607, 32767);
    drain();
    chk("sat24_pos", sat24, 1);
    pulse_clear();
    twrite(1, 1, 0);
    send(-2048, 0, 1, 1, 1'b0, 0, 0);
    drain();
    chk("sat24_q0", sat24, 0);
    chk("sat16_q0", sat16, 0);

    // 6: reset with two items in flight
    rdy_mode = 2;
    @(posedge clk);
    #1;
    send(1, 0, 0, 0, 1'b0, 4096, 4096);
    send(2, 0, 1, 0, 1'b1, 5632, 5632);
    @(negedge clk);
    chk("full_valid", out_vld, 1);
    chk("full_ready", in_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_vld, 0);
    chk("midrst_valid16", out_vld16, 0);
    chk("midrst_ready", in_ready, 1);
    sb.delete();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(1, 0, 5, 0, 1'b0, 10240, 10240);
    send(1, 0, 0, 1, 1'b1, 4352, 4352);
    drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
